// File: rtl/pwm_ramp_if.sv
// ----------------------------------------------------------------------------
// pwm_ramp_if
//   Command handshake between a motor-command source and pwm_ramp.
//
//   cmd_valid  : command present (source -> ramp)
//   cmd_ready  : ramp can take a command (ramp -> source)
//   cmd_period : requested PWM period
//   cmd_duty   : requested compare (on-time)
//   cmd_dir    : requested motor direction
//
//   master : command source side
//   slave  : pwm_ramp side
// ----------------------------------------------------------------------------
interface pwm_ramp_if #(
    parameter int WIDTH = 32
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_period;
    logic [WIDTH-1:0] cmd_duty;
    logic             cmd_dir;

    modport master (
        output cmd_valid,
        output cmd_period,
        output cmd_duty,
        output cmd_dir,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_period,
        input  cmd_duty,
        input  cmd_dir,
        output cmd_ready
    );
endinterface

// File: rtl/pwm_ramp.sv
// ----------------------------------------------------------------------------
// pwm_ramp
//   Command stage in front of the pwm generator. Takes (period, duty, dir)
//   commands through a one-deep pending register, applies them at PWM period
//   boundaries (pwm_done) and slews pwm_compare by at most STEP per boundary.
//   A direction change first ramps compare to zero, then flips motor_dir on a
//   boundary of its own, then ramps up again.
//
//   Parameters
//     WIDTH : width of period / duty / compare values
//     STEP  : largest change of pwm_compare per boundary (>= 1)
//
//   Ports
//     clock       : single clock
//     reset       : synchronous, active-high; overrides every other input
//     cmd         : command handshake (pwm_ramp_if.slave)
//     estop       : emergency stop, level-sensitive; forces compare to 0
//     pwm_done    : one-cycle end-of-period strobe from pwm
//     pwm_period  : period to pwm (registered)
//     pwm_compare : compare to pwm (registered)
//     motor_dir   : direction to the H-bridge (registered)
//     ramp_busy   : compare or direction has not yet reached its target
// ----------------------------------------------------------------------------
module pwm_ramp #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clock,
    input  logic             reset,
    pwm_ramp_if.slave        cmd,
    input  logic             estop,
    input  logic             pwm_done,
    output logic [WIDTH-1:0] pwm_period,
    output logic [WIDTH-1:0] pwm_compare,
    output logic             motor_dir,
    output logic             ramp_busy
);

    localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

    // What a boundary will do, judged on the values after any apply.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RAMP_DOWN,   // reversing: walk compare to zero first
        ST_FLIP,        // reversing, compare already zero: swap direction
        ST_SLEW_UP,     // same direction, compare below target
        ST_SLEW_DOWN    // same direction, compare above target
    } state_t;

    // Registered state
    logic [WIDTH-1:0] tgt_duty;
    logic             tgt_dir;
    logic             pend_valid;
    logic [WIDTH-1:0] pend_period;
    logic [WIDTH-1:0] pend_duty;
    logic             pend_dir;

    // Next-state values
    logic [WIDTH-1:0] period_n;
    logic [WIDTH-1:0] compare_n;
    logic             dir_n;
    logic [WIDTH-1:0] tgt_duty_n;
    logic             tgt_dir_n;
    logic             pend_valid_n;
    logic [WIDTH-1:0] pend_period_n;
    logic [WIDTH-1:0] pend_duty_n;
    logic             pend_dir_n;

    // Intermediate combinational values
    logic             accept;
    logic             apply;
    logic             boundary;
    logic [WIDTH-1:0] eff_cmp;
    logic [WIDTH-1:0] eff_tgt;
    logic             eff_tdir;
    logic [WIDTH-1:0] gap;
    state_t           state;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            pwm_period  <= '0;
            pwm_compare <= '0;
            motor_dir   <= 1'b0;
            tgt_duty    <= '0;
            tgt_dir     <= 1'b0;
            pend_valid  <= 1'b0;
        end else begin
            pwm_period  <= period_n;
            pwm_compare <= compare_n;
            motor_dir   <= dir_n;
            tgt_duty    <= tgt_duty_n;
            tgt_dir     <= tgt_dir_n;
            pend_valid  <= pend_valid_n;
        end
    end

    // NOTE: the pending payload carries no reset; it is only ever read while
    // pend_valid is set, and pend_valid itself is reset.
    always_ff @(posedge clock) begin
        pend_period <= pend_period_n;
        pend_duty   <= pend_duty_n;
        pend_dir    <= pend_dir_n;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default up front so no path through
        // this block can leave one unassigned and infer a latch.
        period_n      = pwm_period;
        compare_n     = pwm_compare;
        dir_n         = motor_dir;
        tgt_duty_n    = tgt_duty;
        tgt_dir_n     = tgt_dir;
        pend_valid_n  = pend_valid;
        pend_period_n = pend_period;
        pend_duty_n   = pend_duty;
        pend_dir_n    = pend_dir;
        eff_cmp       = pwm_compare;
        eff_tgt       = tgt_duty;
        eff_tdir      = tgt_dir;
        gap           = '0;
        state         = ST_IDLE;

        accept = cmd.cmd_valid & ~pend_valid & ~estop;
        // With a zero period pwm never strobes, so apply right away.
        apply    = pend_valid & (pwm_done | (pwm_period == '0));
        boundary = pwm_done | apply;

        // Apply: new period and target; clamp compare into the new period.
        if (apply) begin
            period_n     = pend_period;
            eff_tgt      = (pend_duty < pend_period) ? pend_duty : pend_period;
            eff_tdir     = pend_dir;
            eff_cmp      = (pwm_compare > pend_period) ? pend_period : pwm_compare;
            pend_valid_n = 1'b0;
        end
        tgt_duty_n = eff_tgt;
        tgt_dir_n  = eff_tdir;
        compare_n  = eff_cmp;

        if (motor_dir != eff_tdir) begin
            state = (eff_cmp != '0) ? ST_RAMP_DOWN : ST_FLIP;
        end else if (eff_tgt > eff_cmp) begin
            state = ST_SLEW_UP;
        end else if (eff_tgt < eff_cmp) begin
            state = ST_SLEW_DOWN;
        end

        // One slew step per boundary; the apply shares that same step.
        // All differences are taken larger-minus-smaller, so nothing wraps.
        if (boundary) begin
            unique case (state)
                ST_RAMP_DOWN: compare_n = (eff_cmp > STEP_V) ? eff_cmp - STEP_V : '0;
                ST_FLIP:      dir_n     = eff_tdir;
                ST_SLEW_UP: begin
                    gap       = eff_tgt - eff_cmp;
                    compare_n = eff_cmp + ((gap >= STEP_V) ? STEP_V : gap);
                end
                ST_SLEW_DOWN: begin
                    gap       = eff_cmp - eff_tgt;
                    compare_n = eff_cmp - ((gap >= STEP_V) ? STEP_V : gap);
                end
                default: ;
            endcase
        end

        if (accept) begin
            pend_valid_n  = 1'b1;
            pend_period_n = cmd.cmd_period;
            pend_duty_n   = cmd.cmd_duty;
            pend_dir_n    = cmd.cmd_dir;
        end

        // Emergency stop: drop compare now, forget targets and pending, and
        // pin target direction to the current one so release lands in IDLE.
        if (estop) begin
            period_n     = pwm_period;
            compare_n    = '0;
            dir_n        = motor_dir;
            tgt_duty_n   = '0;
            tgt_dir_n    = motor_dir;
            pend_valid_n = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs derived from registered state
    // ------------------------------------------------------------------
    always_comb begin
        cmd.cmd_ready = ~pend_valid & ~estop;
        ramp_busy     = (pwm_compare != tgt_duty) | (motor_dir != tgt_dir);
    end

endmodule

// File: tb/tb_pwm_ramp.sv
// ----------------------------------------------------------------------------
// tb_pwm_ramp
//   Drives two pwm_ramp instances (STEP=1 and STEP=5, WIDTH=8) with the same
//   stimulus and compares every output each cycle against a behavioural
//   model of the command/ramp rules. Directed scenarios come first, then a
//   randomized phase.
// ----------------------------------------------------------------------------
module tb_pwm_ramp;

    localparam int W = 8;
    localparam int STEPS [2] = '{1, 5};

    logic         clock = 1'b0;
    logic         reset;
    logic         estop;
    logic         pwm_done;
    logic [W-1:0] per_o  [2];
    logic [W-1:0] cmp_o  [2];
    logic         dir_o  [2];
    logic         busy_o [2];
    logic         rdy_o  [2];

    pwm_ramp_if #(.WIDTH(W)) if0 ();
    pwm_ramp_if #(.WIDTH(W)) if1 ();

    assign rdy_o[0] = if0.cmd_ready;
    assign rdy_o[1] = if1.cmd_ready;

    pwm_ramp #(.WIDTH(W), .STEP(1)) u0 (
        .clock       (clock),
        .reset       (reset),
        .cmd         (if0.slave),
        .estop       (estop),
        .pwm_done    (pwm_done),
        .pwm_period  (per_o[0]),
        .pwm_compare (cmp_o[0]),
        .motor_dir   (dir_o[0]),
        .ramp_busy   (busy_o[0])
    );

    pwm_ramp #(.WIDTH(W), .STEP(5)) u1 (
        .clock       (clock),
        .reset       (reset),
        .cmd         (if1.slave),
        .estop       (estop),
        .pwm_done    (pwm_done),
        .pwm_period  (per_o[1]),
        .pwm_compare (cmp_o[1]),
        .motor_dir   (dir_o[1]),
        .ramp_busy   (busy_o[1])
    );

    always #5 clock = ~clock;

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: plain integers, one set per instance
    // ------------------------------------------------------------------
    int m_per [2], m_cmp [2], m_dir [2], m_tgt [2], m_tdir [2];
    int m_pv [2], m_pp [2], m_pd [2], m_pdir [2];
    bit cur_estop;

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // One PWM boundary: reversal walks to zero, then flips; otherwise
    // compare moves toward target by at most the step size.
    function automatic void model_boundary(input int k);
        int s;
        int diff;
        s = STEPS[k];
        if (m_dir[k] != m_tdir[k]) begin
            if (m_cmp[k] == 0) m_dir[k] = m_tdir[k];
            else               m_cmp[k] = m_cmp[k] - min2(s, m_cmp[k]);
        end else begin
            diff = m_tgt[k] - m_cmp[k];
            if (diff > 0)      m_cmp[k] = m_cmp[k] + min2(s, diff);
            else if (diff < 0) m_cmp[k] = m_cmp[k] - min2(s, -diff);
        end
    endfunction

    function automatic void model_tick(input int k, input bit v, input int p, input int d,
                                       input bit dr, input bit es, input bit dn, input bit rs);
        bit acc;
        bit apl;
        if (rs) begin
            m_per[k] = 0; m_cmp[k] = 0; m_dir[k] = 0; m_tgt[k] = 0; m_tdir[k] = 0; m_pv[k] = 0;
        end else if (es) begin
            m_cmp[k] = 0; m_tgt[k] = 0; m_tdir[k] = m_dir[k]; m_pv[k] = 0;
        end else begin
            acc = v && (m_pv[k] == 0);
            apl = (m_pv[k] == 1) && (dn || m_per[k] == 0);
            if (apl) begin
                m_per[k]  = m_pp[k];
                m_tgt[k]  = min2(m_pd[k], m_pp[k]);
                m_tdir[k] = m_pdir[k];
                m_cmp[k]  = min2(m_cmp[k], m_per[k]);
                m_pv[k]   = 0;
            end
            if (apl || dn) model_boundary(k);
            if (acc) begin
                m_pv[k] = 1; m_pp[k] = p; m_pd[k] = d; m_pdir[k] = int'(dr);
            end
        end
    endfunction

    // Drive one clock of stimulus, advance the model, then compare all
    // outputs on the following falling edge.
    task automatic cycle(input bit v, input int p, input int d, input bit dr,
                         input bit es, input bit dn, input bit rs);
        p = p & 255;
        d = d & 255;
        reset = rs; estop = es; pwm_done = dn; cur_estop = es;
        if0.cmd_valid = v; if0.cmd_period = W'(p); if0.cmd_duty = W'(d); if0.cmd_dir = dr;
        if1.cmd_valid = v; if1.cmd_period = W'(p); if1.cmd_duty = W'(d); if1.cmd_dir = dr;
        for (int k = 0; k < 2; k++) model_tick(k, v, p, d, dr, es, dn, rs);
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("u%0d.pwm_period", k),  32'(per_o[k]),  32'(m_per[k]));
            check($sformatf("u%0d.pwm_compare", k), 32'(cmp_o[k]),  32'(m_cmp[k]));
            check($sformatf("u%0d.motor_dir", k),   32'(dir_o[k]),  32'(m_dir[k]));
            check($sformatf("u%0d.cmd_ready", k),   32'(rdy_o[k]),
                  32'((m_pv[k] == 0) && !cur_estop));
            check($sformatf("u%0d.ramp_busy", k),   32'(busy_o[k]),
                  32'((m_cmp[k] != m_tgt[k]) || (m_dir[k] != m_tdir[k])));
        end
    endtask

    task automatic idle(input bit dn);
        cycle(1'b0, 0, 0, 1'b0, 1'b0, dn, 1'b0);
    endtask

    task automatic send(input int p, input int d, input bit dr, input bit dn);
        cycle(1'b1, p, d, dr, 1'b0, dn, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int rev_cmp [6] = '{2, 1, 0, 0, 1, 2};
    int rev_dir [6] = '{0, 0, 0, 1, 1, 1};

    initial begin
        reset = 1'b1; estop = 1'b0; pwm_done = 1'b0; cur_estop = 1'b0;
        if0.cmd_valid = 1'b0; if0.cmd_period = '0; if0.cmd_duty = '0; if0.cmd_dir = 1'b0;
        if1.cmd_valid = 1'b0; if1.cmd_period = '0; if1.cmd_duty = '0; if1.cmd_dir = 1'b0;
        @(negedge clock);

        // Reset state
        do_reset();
        check("reset.period",  32'(per_o[0]),  32'd0);
        check("reset.compare", 32'(cmp_o[0]),  32'd0);
        check("reset.ready",   32'(rdy_o[0]),  32'd1);
        check("reset.busy",    32'(busy_o[0]), 32'd0);

        // Basic ramp: period 0 means apply the cycle after acceptance
        send(4, 2, 1'b0, 1'b0);
        check("basic.pending_ready", 32'(rdy_o[0]), 32'd0);
        idle(1'b0);
        check("basic.apply_period",  32'(per_o[0]),  32'd4);
        check("basic.apply_compare", 32'(cmp_o[0]),  32'd1);
        check("basic.apply_busy",    32'(busy_o[0]), 32'd1);
        idle(1'b0);
        check("basic.hold_no_done",  32'(cmp_o[0]),  32'd1);
        idle(1'b1);
        check("basic.second_step",   32'(cmp_o[0]),  32'd2);
        check("basic.busy_done",     32'(busy_o[0]), 32'd0);

        // Reversal from compare 3, dir 0, period 6
        send(6, 3, 1'b0, 1'b0);
        idle(1'b1);
        check("rev.start_compare", 32'(cmp_o[0]), 32'd3);
        send(6, 2, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            idle(1'b0);
            idle(1'b1);
            check($sformatf("rev.compare[%0d]", i), 32'(cmp_o[0]), 32'(rev_cmp[i]));
            check($sformatf("rev.dir[%0d]", i),     32'(dir_o[0]), 32'(rev_dir[i]));
        end

        // Period shrink clamp: compare 5 / period 8, then period 3 duty 3
        send(8, 5, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);
        check("shrink.pre_compare", 32'(cmp_o[0]), 32'd5);
        send(3, 3, 1'b1, 1'b0);
        idle(1'b1);
        check("shrink.period",  32'(per_o[0]), 32'd3);
        check("shrink.compare", 32'(cmp_o[0]), 32'd3);

        // Back-pressure with cmd_valid held across two commands
        send(4, 1, 1'b1, 1'b0);
        check("bp.ready_after_accept", 32'(rdy_o[0]), 32'd0);
        send(5, 2, 1'b1, 1'b0);
        check("bp.ready_held_low",     32'(rdy_o[0]), 32'd0);
        send(5, 2, 1'b1, 1'b1);
        check("bp.first_applied",      32'(per_o[0]), 32'd4);
        check("bp.ready_reopens",      32'(rdy_o[0]), 32'd1);
        send(5, 2, 1'b1, 1'b0);
        check("bp.second_pending",     32'(rdy_o[0]), 32'd0);
        check("bp.period_unchanged",   32'(per_o[0]), 32'd4);
        idle(1'b1);
        check("bp.second_applied",     32'(per_o[0]), 32'd5);

        // estop mid-ramp at compare 4 with a command pending
        do_reset();
        send(8, 4, 1'b0, 1'b0);
        idle(1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);
        check("estop.pre_compare", 32'(cmp_o[0]), 32'd4);
        send(2, 0, 1'b1, 1'b0);
        cycle(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("estop.compare", 32'(cmp_o[0]), 32'd0);
        check("estop.ready",   32'(rdy_o[0]), 32'd0);
        check("estop.period",  32'(per_o[0]), 32'd8);
        idle(1'b0);
        idle(1'b1);
        check("estop.release_compare", 32'(cmp_o[0]),  32'd0);
        check("estop.release_busy",    32'(busy_o[0]), 32'd0);
        check("estop.pending_dropped", 32'(per_o[0]),  32'd8);

        // Reset mid-ramp
        send(8, 8, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);
        do_reset();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_mid.u%0d.period", k),  32'(per_o[k]),  32'd0);
            check($sformatf("rst_mid.u%0d.compare", k), 32'(cmp_o[k]),  32'd0);
            check($sformatf("rst_mid.u%0d.dir", k),     32'(dir_o[k]),  32'd0);
            check($sformatf("rst_mid.u%0d.busy", k),    32'(busy_o[k]), 32'd0);
        end

        // Large STEP: compare 3 ramping to 0 with STEP=5 must not wrap
        send(10, 3, 1'b0, 1'b0);
        idle(1'b0);
        check("step5.up_compare",   32'(cmp_o[1]), 32'd3);
        send(10, 0, 1'b0, 1'b0);
        idle(1'b1);
        check("step5.down_compare", 32'(cmp_o[1]),  32'd0);
        check("step5.down_busy",    32'(busy_o[1]), 32'd0);

        // Full-scale ramp near 2^WIDTH-1
        send(255, 255, 1'b0, 1'b0);
        for (int i = 0; i < 60; i++) idle(1'b1);

        // Randomized phase
        for (int n = 0; n < 4000; n++) begin
            int p;
            int d;
            case ($urandom_range(3))
                0:       p = 0;
                1:       p = 255;
                default: p = int'($urandom_range(255));
            endcase
            d = ($urandom_range(3) == 0) ? 255 : int'($urandom_range(255));
            cycle($urandom_range(99) < 50, p, d, 1'($urandom_range(1)),
                  $urandom_range(99) < 3, $urandom_range(99) < 30,
                  $urandom_range(999) < 5);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
